// File: rtl/kernel_launch_ctrl.sv
// Host-side launch and memory-arbitration controller for the RISC-V kernel core.
// Owns the single-port imem/dmem: host load/readback when idle, core access while running.
module kernel_launch_ctrl #(
    parameter int AddressWidth_imem = 6,
    parameter int AddressWidth_dmem = 5,
    parameter int DataWidth         = 32,
    parameter int TimeoutCycles     = 1024
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,

    input  logic                         host_cmd_valid,
    output logic                         host_cmd_ready,
    input  logic [1:0]                   host_cmd_op,
    input  logic [AddressWidth_imem-1:0] host_cmd_addr,
    input  logic [DataWidth-1:0]         host_cmd_data,
    output logic                         host_rsp_valid,
    output logic [DataWidth-1:0]         host_rsp_data,

    output logic                         busy,
    output logic                         run_done,
    output logic                         run_timeout,
    output logic [31:0]                  run_cycles,

    output logic                         core_rst,
    output logic                         core_start,
    input  logic                         core_done,
    input  logic [AddressWidth_imem-1:0] core_imem_address0,
    output logic [DataWidth-1:0]         core_imem_q0,
    input  logic [AddressWidth_dmem-1:0] core_dmem_address0,
    input  logic                         core_dmem_we0,
    input  logic [DataWidth-1:0]         core_dmem_d0,
    output logic [DataWidth-1:0]         core_dmem_q0,

    output logic [AddressWidth_imem-1:0] imem_address0,
    output logic                         imem_ce0,
    output logic                         imem_we0,
    output logic [DataWidth-1:0]         imem_d0,
    input  logic [DataWidth-1:0]         imem_q0,

    output logic [AddressWidth_dmem-1:0] dmem_address0,
    output logic                         dmem_ce0,
    output logic                         dmem_we0,
    output logic [DataWidth-1:0]         dmem_d0,
    input  logic [DataWidth-1:0]         dmem_q0
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_RESP,
        START,
        RUN
    } state_t;

    localparam logic [1:0]  OpWrImem  = 2'b00;
    localparam logic [1:0]  OpWrDmem  = 2'b01;
    localparam logic [1:0]  OpRdDmem  = 2'b10;
    localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);

    state_t                         state_q, state_d;
    logic [AddressWidth_dmem-1:0]   rdAddr_q, rdAddr_d;
    logic                           runDone_q, runDone_d;
    logic                           runTimeout_q, runTimeout_d;
    logic [31:0]                    runCycles_q, runCycles_d;
    logic [31:0]                    runCyclesInc;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            rdAddr_q     <= '0;
            runDone_q    <= 1'b0;
            runTimeout_q <= 1'b0;
            runCycles_q  <= '0;
        end else begin
            state_q      <= state_d;
            rdAddr_q     <= rdAddr_d;
            runDone_q    <= runDone_d;
            runTimeout_q <= runTimeout_d;
            runCycles_q  <= runCycles_d;
        end
    end

    // Saturating counter step; the all-ones value is held rather than wrapping.
    assign runCyclesInc = (runCycles_q == '1) ? runCycles_q : runCycles_q + 32'd1;

    always_comb begin
        state_d            = state_q;
        rdAddr_d           = rdAddr_q;
        runDone_d          = runDone_q;
        runTimeout_d       = runTimeout_q;
        runCycles_d        = runCycles_q;

        host_cmd_ready     = 1'b0;
        host_rsp_valid     = 1'b0;
        host_rsp_data      = '0;
        core_rst           = 1'b1;
        core_start         = 1'b0;
        core_imem_q0       = '0;
        core_dmem_q0       = '0;
        imem_address0      = '0;
        imem_ce0           = 1'b0;
        imem_we0           = 1'b0;
        imem_d0            = '0;
        dmem_address0      = '0;
        dmem_ce0           = 1'b0;
        dmem_we0           = 1'b0;
        dmem_d0            = '0;

        unique case (state_q)
            IDLE: begin
                host_cmd_ready = 1'b1;
                if (host_cmd_valid) begin
                    unique case (host_cmd_op)
                        OpWrImem: begin
                            imem_ce0      = 1'b1;
                            imem_we0      = 1'b1;
                            imem_address0 = host_cmd_addr;
                            imem_d0       = host_cmd_data;
                        end
                        OpWrDmem: begin
                            dmem_ce0      = 1'b1;
                            dmem_we0      = 1'b1;
                            dmem_address0 = host_cmd_addr[AddressWidth_dmem-1:0];
                            dmem_d0       = host_cmd_data;
                        end
                        OpRdDmem: begin
                            rdAddr_d = host_cmd_addr[AddressWidth_dmem-1:0];
                            state_d  = RD_ISSUE;
                        end
                        default: begin
                            runDone_d    = 1'b0;
                            runTimeout_d = 1'b0;
                            runCycles_d  = '0;
                            state_d      = START;
                        end
                    endcase
                end
            end
            RD_ISSUE: begin
                dmem_ce0      = 1'b1;
                dmem_address0 = rdAddr_q;
                state_d       = RD_RESP;
            end
            RD_RESP: begin
                host_rsp_valid = 1'b1;
                host_rsp_data  = dmem_q0;
                state_d        = IDLE;
            end
            START: begin
                core_rst   = 1'b0;
                core_start = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                core_rst      = 1'b0;
                imem_ce0      = 1'b1;
                imem_address0 = core_imem_address0;
                dmem_ce0      = 1'b1;
                dmem_address0 = core_dmem_address0;
                dmem_we0      = core_dmem_we0;
                dmem_d0       = core_dmem_d0;
                core_imem_q0  = imem_q0;
                core_dmem_q0  = dmem_q0;
                // Completion takes priority over a timeout landing on the same cycle.
                if (core_done) begin
                    runDone_d   = 1'b1;
                    runCycles_d = runCyclesInc;
                    state_d     = IDLE;
                end else if (runCycles_q == TimeoutLast) begin
                    runTimeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    runCycles_d = runCyclesInc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign run_done    = runDone_q;
    assign run_timeout = runTimeout_q;
    assign run_cycles  = runCycles_q;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Self-checking bench for kernel_launch_ctrl: directed host/launch sequence plus
// randomized traffic checked against array shadows of both memories and run outcome arithmetic.
module tb_kernel_launch_ctrl;

    localparam int AI = 6;
    localparam int AD = 5;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          ap_clk, ap_rst;
    logic          host_cmd_valid, host_cmd_ready;
    logic [1:0]    host_cmd_op;
    logic [AI-1:0] host_cmd_addr;
    logic [DW-1:0] host_cmd_data;
    logic          host_rsp_valid;
    logic [DW-1:0] host_rsp_data;
    logic          busy, run_done, run_timeout;
    logic [31:0]   run_cycles;
    logic          core_rst, core_start, core_done;
    logic [AI-1:0] core_imem_address0;
    logic [DW-1:0] core_imem_q0;
    logic [AD-1:0] core_dmem_address0;
    logic          core_dmem_we0;
    logic [DW-1:0] core_dmem_d0, core_dmem_q0;
    logic [AI-1:0] imem_address0;
    logic          imem_ce0, imem_we0;
    logic [DW-1:0] imem_d0, imem_q0;
    logic [AD-1:0] dmem_address0;
    logic          dmem_ce0, dmem_we0;
    logic [DW-1:0] dmem_d0, dmem_q0;

    kernel_launch_ctrl #(
        .AddressWidth_imem(AI), .AddressWidth_dmem(AD),
        .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_cmd_addr(host_cmd_addr), .host_cmd_data(host_cmd_data),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
        .busy(busy), .run_done(run_done), .run_timeout(run_timeout), .run_cycles(run_cycles),
        .core_rst(core_rst), .core_start(core_start), .core_done(core_done),
        .core_imem_address0(core_imem_address0), .core_imem_q0(core_imem_q0),
        .core_dmem_address0(core_dmem_address0), .core_dmem_we0(core_dmem_we0),
        .core_dmem_d0(core_dmem_d0), .core_dmem_q0(core_dmem_q0),
        .imem_address0(imem_address0), .imem_ce0(imem_ce0), .imem_we0(imem_we0),
        .imem_d0(imem_d0), .imem_q0(imem_q0),
        .dmem_address0(dmem_address0), .dmem_ce0(dmem_ce0), .dmem_we0(dmem_we0),
        .dmem_d0(dmem_d0), .dmem_q0(dmem_q0)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Single-port RAMs with read-first registered output, as seen by the controller.
    logic [DW-1:0] imemArr [2**AI];
    logic [DW-1:0] dmemArr [2**AD];
    logic [DW-1:0] imemRef [2**AI];
    logic [DW-1:0] dmemRef [2**AD];

    always @(posedge ap_clk) begin
        if (imem_ce0) begin
            if (imem_we0) imemArr[imem_address0] <= imem_d0;
            imem_q0 <= imemArr[imem_address0];
        end
        if (dmem_ce0) begin
            if (dmem_we0) dmemArr[dmem_address0] <= dmem_d0;
            dmem_q0 <= dmemArr[dmem_address0];
        end
    end

    int vectors;
    int miscompares;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveIdle();
        host_cmd_valid     = 1'b0;
        host_cmd_op        = 2'b00;
        host_cmd_addr      = '0;
        host_cmd_data      = '0;
        core_done          = 1'b0;
        core_imem_address0 = '0;
        core_dmem_address0 = '0;
        core_dmem_we0      = 1'b0;
        core_dmem_d0       = '0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_core_rst"}, 64'(core_rst), 64'(1));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_flags"}, 64'({core_start, host_rsp_valid, run_done, run_timeout}), 64'(0));
        checkOutput({tag, "_cycles"}, 64'(run_cycles), 64'(0));
        checkOutput({tag, "_rsp_data"}, 64'(host_rsp_data), 64'(0));
        checkOutput({tag, "_mem_en"}, 64'({imem_ce0, imem_we0, dmem_ce0, dmem_we0}), 64'(0));
    endtask

    task automatic applyStimulusWrite(input logic [1:0] op, input logic [AI-1:0] addr,
                                      input logic [DW-1:0] data);
        @(negedge ap_clk);
        host_cmd_valid = 1'b1;
        host_cmd_op    = op;
        host_cmd_addr  = addr;
        host_cmd_data  = data;
        #1;
        checkOutput("wr_ready", 64'(host_cmd_ready), 64'(1));
        checkOutput("wr_rsp", 64'(host_rsp_valid), 64'(0));
        if (op == 2'b00) begin
            checkOutput("wr_imem_en", 64'({imem_ce0, imem_we0, dmem_we0}), 64'(3'b110));
            checkOutput("wr_imem_addr", 64'(imem_address0), 64'(addr));
            checkOutput("wr_imem_d", 64'(imem_d0), 64'(data));
            imemRef[addr] = data;
        end else begin
            checkOutput("wr_dmem_en", 64'({dmem_ce0, dmem_we0, imem_we0}), 64'(3'b110));
            checkOutput("wr_dmem_addr", 64'(dmem_address0), 64'(addr[AD-1:0]));
            checkOutput("wr_dmem_d", 64'(dmem_d0), 64'(data));
            dmemRef[addr[AD-1:0]] = data;
        end
    endtask

    task automatic applyStimulusRead(input logic [AI-1:0] addr);
        logic [DW-1:0] expData;
        expData = dmemRef[addr[AD-1:0]];
        @(negedge ap_clk);
        host_cmd_valid = 1'b1;
        host_cmd_op    = 2'b10;
        host_cmd_addr  = addr;
        #1;
        checkOutput("rd_accept_ready", 64'(host_cmd_ready), 64'(1));
        @(negedge ap_clk);
        host_cmd_valid = 1'b0;
        #1;
        checkOutput("rd_issue_ready", 64'(host_cmd_ready), 64'(0));
        checkOutput("rd_issue_rsp", 64'(host_rsp_valid), 64'(0));
        checkOutput("rd_issue_ce", 64'({dmem_ce0, dmem_we0}), 64'(2'b10));
        checkOutput("rd_issue_addr", 64'(dmem_address0), 64'(addr[AD-1:0]));
        @(negedge ap_clk);
        #1;
        checkOutput("rd_resp_ready", 64'(host_cmd_ready), 64'(0));
        checkOutput("rd_resp_valid", 64'(host_rsp_valid), 64'(1));
        checkOutput("rd_resp_data", 64'(host_rsp_data), 64'(expData));
        @(negedge ap_clk);
        #1;
        checkOutput("rd_after_valid", 64'(host_rsp_valid), 64'(0));
        checkOutput("rd_after_ready", 64'(host_cmd_ready), 64'(1));
    endtask

    // doneAt = 0: core never finishes. abortAt != 0: ap_rst pulses on that RUN cycle.
    task automatic applyStimulusLaunch(input int doneAt, input bit holdWr, input logic [AD-1:0] hAddr,
                                       input logic [DW-1:0] hData, input int abortAt);
        bit            ended, aborted, haveQ;
        bit            expDone, expTimeout;
        int            expCycles;
        logic [AI-1:0] ia;
        logic [AD-1:0] da;
        logic [DW-1:0] expIq, expDq;
        ended = 0; aborted = 0; haveQ = 0;
        expDone = 0; expTimeout = 0; expCycles = 0;
        expIq = '0; expDq = '0;

        @(negedge ap_clk);
        host_cmd_valid = 1'b1;
        host_cmd_op    = 2'b11;
        host_cmd_addr  = AI'($urandom);
        #1;
        checkOutput("launch_ready", 64'(host_cmd_ready), 64'(1));
        checkOutput("launch_core_rst", 64'(core_rst), 64'(1));

        @(negedge ap_clk);
        host_cmd_valid = holdWr;
        host_cmd_op    = 2'b01;
        host_cmd_addr  = {1'b1, hAddr};
        host_cmd_data  = hData;
        core_done      = 1'b1;
        core_dmem_we0  = 1'b1;
        #1;
        checkOutput("start_pulse", 64'({core_start, core_rst, busy, host_cmd_ready}), 64'(4'b1010));
        checkOutput("start_flags", 64'({run_done, run_timeout}), 64'(0));
        checkOutput("start_cycles", 64'(run_cycles), 64'(0));
        checkOutput("start_no_core_wr", 64'(dmem_we0), 64'(0));
        checkOutput("start_core_q", 64'(core_dmem_q0), 64'(0));

        for (int n = 1; n <= TO && !ended; n++) begin
            @(negedge ap_clk);
            ia = AI'($urandom);
            da = (n == 3) ? AD'(2) : AD'($urandom);
            core_imem_address0 = ia;
            core_dmem_address0 = da;
            core_dmem_d0       = $urandom;
            core_dmem_we0      = (n == abortAt) ? 1'b0 : ((n == 3) || ($urandom_range(0, 1) == 1));
            core_done          = (n == doneAt);
            #1;
            checkOutput("run_ctrl", 64'({core_start, core_rst, busy, host_cmd_ready}), 64'(4'b0010));
            checkOutput("run_cycles_live", 64'(run_cycles), 64'(n - 1));
            checkOutput("run_imem_port", 64'({imem_ce0, imem_we0, imem_address0}), 64'({2'b10, ia}));
            checkOutput("run_dmem_port", 64'({dmem_ce0, dmem_we0, dmem_address0}),
                        64'({1'b1, core_dmem_we0, da}));
            checkOutput("run_dmem_d", 64'(dmem_d0), 64'(core_dmem_d0));
            if (haveQ) begin
                checkOutput("run_imem_q", 64'(core_imem_q0), 64'(expIq));
                checkOutput("run_dmem_q", 64'(core_dmem_q0), 64'(expDq));
            end
            expIq = imemRef[ia];
            expDq = dmemRef[da];
            haveQ = 1;
            if (n == abortAt) begin
                #2 ap_rst = 1'b1;
                #1;
                checkResetValues("abort");
                @(negedge ap_clk);
                ap_rst = 1'b0;
                driveIdle();
                ended = 1; aborted = 1;
            end else begin
                if (core_dmem_we0) dmemRef[da] = core_dmem_d0;
                if (n == doneAt) begin
                    ended = 1; expDone = 1; expCycles = n;
                end else if (n == TO) begin
                    ended = 1; expTimeout = 1; expCycles = TO - 1;
                end
            end
        end

        if (!aborted) begin
            @(negedge ap_clk);
            core_done          = ($urandom_range(0, 1) == 1);
            core_dmem_we0      = 1'b1;
            core_dmem_address0 = AD'($urandom);
            #1;
            checkOutput("end_ctrl", 64'({core_start, core_rst, busy, host_cmd_ready}), 64'(4'b0101));
            checkOutput("end_flags", 64'({run_done, run_timeout}), 64'({expDone, expTimeout}));
            checkOutput("end_cycles", 64'(run_cycles), 64'(expCycles));
            checkOutput("end_core_q", 64'({core_imem_q0, core_dmem_q0}), 64'(0));
            checkOutput("end_dmem_we", 64'(dmem_we0), 64'(holdWr));
            if (holdWr) begin
                checkOutput("held_wr_addr", 64'(dmem_address0), 64'(hAddr));
                checkOutput("held_wr_d", 64'(dmem_d0), 64'(hData));
                dmemRef[hAddr] = hData;
            end
            @(negedge ap_clk);
            driveIdle();
            #1;
            checkOutput("idle_flags_sticky", 64'({run_done, run_timeout, busy}), 64'({expDone, expTimeout, 1'b0}));
            checkOutput("idle_cycles_sticky", 64'(run_cycles), 64'(expCycles));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 2**AI; i++) begin imemArr[i] = '0; imemRef[i] = '0; end
        for (int i = 0; i < 2**AD; i++) begin dmemArr[i] = '0; dmemRef[i] = '0; end
        imem_q0 = '0;
        dmem_q0 = '0;
        driveIdle();
        ap_rst = 1'b1;
        #12;
        checkResetValues("reset");
        @(negedge ap_clk);
        ap_rst = 1'b0;

        $display("[TB] host load imem 0..3 and dmem 5");
        for (int a = 0; a < 4; a++) applyStimulusWrite(2'b00, AI'(a), 32'h0000_0013);
        applyStimulusWrite(2'b01, AI'(5), 32'hDEAD_BEEF);

        $display("[TB] host readback dmem 5");
        applyStimulusRead(AI'(5));
        applyStimulusRead(AI'(6'h25));

        $display("[TB] launch, core done on RUN cycle 10");
        applyStimulusLaunch(10, 1'b0, '0, '0, 0);

        $display("[TB] launch, timeout");
        applyStimulusLaunch(0, 1'b0, '0, '0, 0);

        $display("[TB] launch with held host write, then read back core and host writes");
        applyStimulusLaunch(7, 1'b1, AD'(7), 32'hCAFE_0007, 0);
        applyStimulusRead(AI'(2));
        applyStimulusRead(AI'(7));

        $display("[TB] done on last cycle, done on first cycle");
        applyStimulusLaunch(TO, 1'b0, '0, '0, 0);
        applyStimulusLaunch(1, 1'b0, '0, '0, 0);

        $display("[TB] randomized host traffic and launches");
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 4; w++)
                applyStimulusWrite(2'($urandom_range(0, 1)), AI'($urandom), $urandom);
            applyStimulusLaunch($urandom_range(1, 20), ($urandom_range(0, 1) == 1), AD'($urandom), $urandom, 0);
            applyStimulusRead(AI'($urandom));
            applyStimulusRead(AI'(2));
        end

        $display("[TB] async reset mid-run");
        applyStimulusLaunch(0, 1'b0, '0, '0, 5);
        #1;
        checkResetValues("post_abort");
        applyStimulusRead(AI'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kernel_launch_ctrl.md
Name: kernel_launch_ctrl

Overview:
Host-side launch and memory-arbitration controller for the RISC-V kernel core. Owns the single-port instruction and data memories.
- Outside a run: the host loads imem/dmem and reads dmem back through a valid/ready command port.
- During a run: both memory ports are muxed to the core, the core start handshake is sequenced, and execution time is counted.
- On completion or timeout: the core is returned to reset and memory ownership passes back to the host.

Parameters:
AddressWidth_imem, 6, imem word-address width
AddressWidth_dmem, 5, dmem word-address width (must be <= AddressWidth_imem)
DataWidth, 32, memory word width
TimeoutCycles, 1024, maximum RUN cycles before forced abort (>= 2)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset; asynchronous, active-high
host_cmd_valid  in  1  command valid
host_cmd_ready  out  1  command accepted when valid&&ready
host_cmd_op  in  2  00 write imem, 01 write dmem, 10 read dmem, 11 launch
host_cmd_addr  in  AddressWidth_imem  word address (dmem uses low AddressWidth_dmem bits)
host_cmd_data  in  DataWidth  write data
host_rsp_valid  out  1  one-cycle read-response strobe
host_rsp_data  out  DataWidth  read data, valid with host_rsp_valid
busy  out  1  1 outside IDLE
run_done  out  1  sticky: last launch ended by core_done
run_timeout  out  1  sticky: last launch ended by timeout
run_cycles  out  32  RUN cycles of last/current launch
core_rst  out  1  reset to core
core_start  out  1  core ap_start pulse
core_done  in  1  core ap_done
core_imem_address0  in  AddressWidth_imem  core fetch address
core_imem_q0  out  DataWidth  fetch data to core
core_dmem_address0  in  AddressWidth_dmem  core data address
core_dmem_we0  in  1  core write enable
core_dmem_d0  in  DataWidth  core write data
core_dmem_q0  out  DataWidth  read data to core
imem_address0  out  AddressWidth_imem  imem address
imem_ce0  out  1  imem enable
imem_we0  out  1  imem write
imem_d0  out  DataWidth  imem write data
imem_q0  in  DataWidth  imem read data (1-cycle registered)
dmem_address0  out  AddressWidth_dmem  dmem address
dmem_ce0  out  1  dmem enable
dmem_we0  out  1  dmem write
dmem_d0  out  DataWidth  dmem write data
dmem_q0  in  DataWidth  dmem read data (1-cycle registered)

Behaviour:
- Reset (async assert, sync release): state=IDLE; core_rst=1; core_start=0; host_rsp_valid=0; host_rsp_data=0; run_done=0; run_timeout=0; run_cycles=0; busy=0; all memory enables/writes=0.
- States: IDLE, RD_ISSUE, RD_RESP, START, RUN.
- host_cmd_ready=1 only in IDLE; commands in every other state stall and are not dropped.
- IDLE, write accepted (op 00/01): same cycle, target ce=we=1, address = host_cmd_addr, d = host_cmd_data; state stays IDLE; back-to-back writes run at 1/cycle.
- IDLE, read accepted (op 10): address latched; go to RD_ISSUE.
- RD_ISSUE: dmem_ce0=1 with the latched address.
- RD_RESP: host_rsp_valid=1, host_rsp_data=dmem_q0; return to IDLE. The response appears 2 edges after the accept edge.
- IDLE, launch accepted (op 11): clear run_done, run_timeout and run_cycles; go to START.
- START (1 cycle): core_rst=0, core_start=1; go to RUN.
- RUN: core_rst=0, core_start=0.
  - imem: ce=1, address=core_imem_address0, we=0.
  - dmem: ce=1, address/we/d from core.
  - core_*_q0 = memory q0; outside RUN, core_*_q0 = 0 and core dmem writes are ignored.
  - run_cycles increments by 1 per RUN cycle, saturating at 2^32-1.
- RUN exit:
  - core_done=1 → run_done=1, back to IDLE.
  - Else if run_cycles == TimeoutCycles-1 → run_timeout=1, back to IDLE.
  - If both hold in the same cycle, done wins.
  - core_rst=1 from the IDLE cycle onward.
- core_done is ignored outside RUN.
- Asserting ap_rst mid-RUN or mid-read aborts immediately to reset values; no response is emitted.

Test Plan:
1. Write imem addr 0..3 with 0x00000013, then dmem addr 5 = 0xDEADBEEF. Expect: 4+1 consecutive accepts, one cycle each, with correct we/address/d; no host_rsp_valid.
2. Read dmem addr 5. Expect: host_rsp_valid exactly 2 edges after accept, data 0xDEADBEEF; host_cmd_ready=0 for the two intermediate cycles.
3. Launch with a core model raising core_done on RUN cycle 10. Expect: core_start pulse of 1 cycle; run_done=1, run_timeout=0, run_cycles=10; core_rst=1 after; cmd_ready returns to 1.
4. Launch with TimeoutCycles=16 and core_done never asserted. Expect: run_timeout=1 after 16 RUN cycles, run_cycles=15; then core_done=1 in IDLE leaves run_done at 0.
5. Hold a write command valid during RUN. Expect: not accepted until IDLE; the core model's dmem write to addr 2 during RUN is visible when the host reads addr 2 afterwards.
6. Assert ap_rst asynchronously mid-RUN (between edges). Expect: core_rst=1 and busy=0 immediately; all flags and run_cycles=0; no rsp.
